// File: rtl/k12a_sp_pkg.sv
// Shared types and helpers for the k12a stack-pointer bank.
// The strobe decode priority lives here so every user sees the same ordering.
package k12a_sp_pkg;

  typedef enum logic [1:0] {
    SP_OP_NONE,
    SP_OP_STORE,
    SP_OP_PUSH,
    SP_OP_POP
  } sp_op_t;

  localparam int SP_STEP1 = 1;
  localparam int SP_STEP2 = 2;

  function automatic int sp_sel_width(input int num_sp);
    return (num_sp <= 2) ? 1 : $clog2(num_sp);
  endfunction

  // A store overrides everything; a push and pop together cancel out.
  function automatic sp_op_t sp_decode_op(input logic store, input logic push, input logic pop);
    sp_op_t op;
    op = SP_OP_NONE;
    if (store)
      op = SP_OP_STORE;
    else if (push && !pop)
      op = SP_OP_PUSH;
    else if (pop && !push)
      op = SP_OP_POP;
    return op;
  endfunction

endpackage

// File: rtl/k12a_sp_bound_check.sv
// Combinational next-value and legality check for one push/pop on a stack pointer.
// Stores are not handled here; the bank writes the bus value directly.
module k12a_sp_bound_check
  import k12a_sp_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = 16,
  parameter int                    CHECK_BOUNDS = 0,
  parameter logic [ADDR_WIDTH-1:0] LOW_LIMIT    = '0,
  parameter logic [ADDR_WIDTH-1:0] HIGH_LIMIT   = '1
) (
  input  logic [ADDR_WIDTH-1:0] ptr,
  input  sp_op_t                op,
  input  logic [ADDR_WIDTH-1:0] step,
  output logic [ADDR_WIDTH-1:0] next_ptr,
  output logic                  commit,
  output logic                  overflow,
  output logic                  underflow
);

  logic [ADDR_WIDTH:0] dec_ext;
  logic [ADDR_WIDTH:0] inc_ext;
  logic                below_low;
  logic                above_high;
  logic                push_ok;
  logic                pop_ok;

  // One extra bit catches the borrow/carry out of the pointer width.
  assign dec_ext = {1'b0, ptr} - {1'b0, step};
  assign inc_ext = {1'b0, ptr} + {1'b0, step};

  // Limit compares done as subtractions so the sign bit is the answer.
  assign below_low  = 1'(({1'b0, dec_ext[ADDR_WIDTH-1:0]} - {1'b0, LOW_LIMIT}) >> ADDR_WIDTH);
  assign above_high = 1'(({1'b0, HIGH_LIMIT} - {1'b0, inc_ext[ADDR_WIDTH-1:0]}) >> ADDR_WIDTH);

  assign push_ok = (CHECK_BOUNDS == 0) || (!dec_ext[ADDR_WIDTH] && !below_low);
  assign pop_ok  = (CHECK_BOUNDS == 0) || (!inc_ext[ADDR_WIDTH] && !above_high);

  always_comb begin
    next_ptr  = ptr;
    commit    = 1'b0;
    overflow  = 1'b0;
    underflow = 1'b0;
    unique case (op)
      SP_OP_PUSH: begin
        next_ptr = dec_ext[ADDR_WIDTH-1:0];
        commit   = push_ok;
        overflow = !push_ok;
      end
      SP_OP_POP: begin
        next_ptr  = inc_ext[ADDR_WIDTH-1:0];
        commit    = pop_ok;
        underflow = !pop_ok;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/k12a_sp_bank.sv
// Bank of NUM_SP stack pointers on the shared tri-state address bus,
// with native push/pop by 1 or 2 and optional bounds checking with sticky faults.
module k12a_sp_bank
  import k12a_sp_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = 16,
  parameter int                    NUM_SP       = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_VALUE  = '0,
  parameter int                    CHECK_BOUNDS = 0,
  parameter logic [ADDR_WIDTH-1:0] LOW_LIMIT    = '0,
  parameter logic [ADDR_WIDTH-1:0] HIGH_LIMIT   = '1,
  localparam int                   SELW         = sp_sel_width(NUM_SP)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [SELW-1:0]       sp_sel,
  input  logic                  sp_load_n,
  input  logic                  sp_store,
  input  logic                  sp_push,
  input  logic                  sp_pop,
  input  logic                  sp_step2,
  input  logic                  err_clear,
  inout  wire  [ADDR_WIDTH-1:0] addr_bus,
  output logic [ADDR_WIDTH-1:0] sp,
  output logic                  sp_overflow,
  output logic                  sp_underflow
);

  logic [ADDR_WIDTH-1:0] sp_q [NUM_SP];
  logic [ADDR_WIDTH-1:0] cur_ptr;
  logic                  sel_valid;
  logic [ADDR_WIDTH-1:0] step;
  sp_op_t                op;
  logic [ADDR_WIDTH-1:0] next_ptr;
  logic                  commit;
  logic                  ovf_event;
  logic                  udf_event;

  // Out-of-range selects read as zero and leave valid_sel low, which blocks writes and bus drive.
  always_comb begin
    cur_ptr   = '0;
    sel_valid = 1'b0;
    for (int i = 0; i < NUM_SP; i++) begin
      if (sp_sel == SELW'(i)) begin
        cur_ptr   = sp_q[i];
        sel_valid = 1'b1;
      end
    end
  end

  assign sp       = cur_ptr;
  assign step     = sp_step2 ? ADDR_WIDTH'(SP_STEP2) : ADDR_WIDTH'(SP_STEP1);
  assign op       = sel_valid ? sp_decode_op(sp_store, sp_push, sp_pop) : SP_OP_NONE;
  assign addr_bus = (reset_n && !sp_load_n && sel_valid) ? cur_ptr : 'z;

  k12a_sp_bound_check #(
    .ADDR_WIDTH   (ADDR_WIDTH),
    .CHECK_BOUNDS (CHECK_BOUNDS),
    .LOW_LIMIT    (LOW_LIMIT),
    .HIGH_LIMIT   (HIGH_LIMIT)
  ) u_bound_check (
    .ptr       (cur_ptr),
    .op        (op),
    .step      (step),
    .next_ptr  (next_ptr),
    .commit    (commit),
    .overflow  (ovf_event),
    .underflow (udf_event)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_SP; i++) sp_q[i] <= RESET_VALUE;
      sp_overflow  <= 1'b0;
      sp_underflow <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_SP; i++) begin
        if (sp_sel == SELW'(i)) begin
          if (op == SP_OP_STORE)
            sp_q[i] <= addr_bus;
          else if (commit)
            sp_q[i] <= next_ptr;
        end
      end
      // A fresh fault outranks err_clear so it is never lost.
      if (ovf_event)
        sp_overflow <= 1'b1;
      else if (err_clear)
        sp_overflow <= 1'b0;
      if (udf_event)
        sp_underflow <= 1'b1;
      else if (err_clear)
        sp_underflow <= 1'b0;
    end
  end

endmodule
